// File: rtl/queue_rd_ctrl.sv
// queue_rd_ctrl: drains one switch queue as a packet sized by the occupancy snapshotted at port grant.
// Latency: port_req 1 cycle after occupancy, first beat 1 cycle after grant; a beat is held while !out_rdy.
// Option QUEUE_RD_TIMEOUT_EN: drop port_req for one cycle after GNT_TIMEOUT ungranted request cycles.
module queue_rd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_SIZE  = 64
`ifdef QUEUE_RD_TIMEOUT_EN
   ,
   parameter int GNT_TIMEOUT = 16
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(FIFO_SIZE):0]   fifo_index,
   input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
   output logic                         fifo_rd_en,
   output logic                         port_req,
   input  logic                         port_gnt,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_vld,
   output logic                         out_eop,
   input  logic                         out_rdy,
   output logic                         busy
);

   localparam int CW = $clog2(FIFO_SIZE) + 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER
`ifdef QUEUE_RD_TIMEOUT_EN
      ,
      BACKOFF
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] remaining;
   logic          slot_free;

`ifdef QUEUE_RD_TIMEOUT_EN
   localparam int TW = $clog2(GNT_TIMEOUT) + 1;
   logic [TW-1:0] to_cnt;
`endif

   assign slot_free  = !out_vld || out_rdy;
   assign fifo_rd_en = !rst && (state == XFER) && slot_free && (remaining != '0);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         port_req  <= 1'b0;
         out_vld   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
         remaining <= '0;
`ifdef QUEUE_RD_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_index != '0) begin
                  state    <= REQ;
                  port_req <= 1'b1;
               end
            end
            REQ: begin
               if (port_gnt) begin
`ifdef QUEUE_RD_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  // Occupancy at grant fixes the packet length; later writes wait for the next packet.
                  if (fifo_index != '0) begin
                     remaining <= fifo_index;
                     state     <= XFER;
                  end else begin
                     state    <= IDLE;
                     port_req <= 1'b0;
                  end
               end
`ifdef QUEUE_RD_TIMEOUT_EN
               else if (to_cnt == TW'(GNT_TIMEOUT - 1)) begin
                  to_cnt   <= '0;
                  state    <= BACKOFF;
                  port_req <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
`endif
            end
            XFER: begin
               if (slot_free) begin
                  if (remaining != '0) begin
                     out_data  <= fifo_rd_data;
                     out_vld   <= 1'b1;
                     out_eop   <= (remaining == CW'(1));
                     remaining <= remaining - CW'(1);
                  end else begin
                     out_vld <= 1'b0;
                     out_eop <= 1'b0;
                  end
               end
               // Port stays locked until the eop beat is taken, regardless of port_gnt.
               if (out_vld && out_eop && out_rdy) begin
                  state    <= IDLE;
                  port_req <= 1'b0;
               end
            end
`ifdef QUEUE_RD_TIMEOUT_EN
            BACKOFF: begin
               to_cnt <= '0;
               if (fifo_index != '0) begin
                  state    <= REQ;
                  port_req <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               port_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_queue_rd_ctrl.sv
// Directed bench for queue_rd_ctrl with a pointer-based FIFO model feeding the controller.
module tb_queue_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] fifo_index;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en;
   logic       port_req;
   logic       port_gnt = 1'b0;
   logic [7:0] out_data;
   logic       out_vld;
   logic       out_eop;
   logic       out_rdy = 1'b1;
   logic       busy;

   int n_chk = 0;
   int n_err = 0;

   queue_rd_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_index   (fifo_index),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .port_req     (port_req),
      .port_gnt     (port_gnt),
      .out_data     (out_data),
      .out_vld      (out_vld),
      .out_eop      (out_eop),
      .out_rdy      (out_rdy),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: bulk writes of push_n entries (data push_base+i) per edge, pops on fifo_rd_en.
   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   int         push_n = 0;
   logic [7:0] push_base = 8'd0;

   assign fifo_index   = 7'(wr_ptr - rd_ptr);
   assign fifo_rd_data = mem[rd_ptr];

   always @(posedge clk) begin
      if (push_n != 0) begin
         for (int i = 0; i < push_n; i++)
            mem[wr_ptr + 8'(i)] <= push_base + 8'(i);
         wr_ptr <= wr_ptr + 8'(push_n);
      end
      if (fifo_rd_en)
         rd_ptr <= rd_ptr + 8'd1;
   end

   // Output monitor, sampled mid-cycle.
   logic [7:0] beat_q [$];
   logic       eop_q  [$];
   int         pops = 0;
   int         stab_viol = 0;
   int         bp_pop_viol = 0;
   int         empty_pop_viol = 0;
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data = 8'd0;
   logic       prev_eop = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && (!out_vld || out_data != prev_data || out_eop != prev_eop))
            stab_viol++;
         if (fifo_rd_en && out_vld && !out_rdy) bp_pop_viol++;
         if (fifo_rd_en && fifo_index == 7'd0) empty_pop_viol++;
         if (fifo_rd_en) pops++;
         if (out_vld && out_rdy) begin
            beat_q.push_back(out_data);
            eop_q.push_back(out_eop);
         end
         prev_hold = out_vld && !out_rdy;
         prev_data = out_data;
         prev_eop  = out_eop;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int n, input logic [7:0] base);
      push_n    = n;
      push_base = base;
      tick();
      push_n = 0;
   endtask

   task automatic wait_req(input string tag);
      int k;
      k = 0;
      while (!port_req && k < 50) begin
         tick();
         k++;
      end
      if (!port_req) chk({tag, "_req_timeout"}, 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      if (busy) chk({tag, "_idle_timeout"}, 0, 1);
   endtask

   task automatic grant;
      port_gnt = 1'b1;
      tick();
      port_gnt = 1'b0;
   endtask

   task automatic check_pkt(input string tag, input int n, input logic [7:0] base, input int npops);
      logic [7:0] e;
      chk({tag, "_len"}, beat_q.size(), n);
      chk({tag, "_pops"}, pops, npops);
      for (int i = 0; i < n && i < beat_q.size(); i++) begin
         e = base + 8'(i);
         chk($sformatf("%s_data%0d", tag, i), int'(beat_q[i]), int'(e));
         chk($sformatf("%s_eop%0d", tag, i), int'(eop_q[i]), (i == n - 1) ? 1 : 0);
      end
      beat_q.delete();
      eop_q.delete();
      pops = 0;
   endtask

   initial begin
      int hi;
      int lo;
      logic [3:0] pat;

      // Asynchronous reset, checked before any clock edge.
      #3 rst = 1'b1;
      #1;
      chk("rst_port_req", port_req, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_eop", out_eop, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single entry, grant two cycles after request.
      push(1, 8'hA5);
      chk("t1_req_lat0", port_req, 0);
      tick();
      chk("t1_req_lat1", port_req, 1);
      chk("t1_busy", busy, 1);
      tick();
      tick();
      grant();
      chk("t1_vld_before", out_vld, 0);
      tick();
      chk("t1_vld", out_vld, 1);
      chk("t1_eop", out_eop, 1);
      chk("t1_data", out_data, 8'hA5);
      tick();
      chk("t1_req_rel", port_req, 0);
      chk("t1_busy_rel", busy, 0);
      chk("t1_vld_rel", out_vld, 0);
      check_pkt("t1", 1, 8'hA5, 1);

      // Full queue, immediate grant, continuous ready.
      push(64, 8'h00);
      chk("t2_index", fifo_index, 64);
      wait_req("t2");
      grant();
      hi = 0;
      while (!(out_vld && out_eop) && hi < 200) begin
         tick();
         hi++;
      end
      chk("t2_busy_at_eop", busy, 1);
      tick();
      chk("t2_busy_after", busy, 0);
      chk("t2_req_after", port_req, 0);
      check_pkt("t2", 64, 8'h00, 64);

      // Backpressure with out_rdy pattern 1,0,0,1.
      push(4, 8'h10);
      wait_req("t3");
      grant();
      pat = 4'b1001;
      hi = 0;
      while (busy && hi < 100) begin
         out_rdy = pat[hi % 4];
         tick();
         hi++;
      end
      out_rdy = 1'b1;
      wait_idle("t3");
      check_pkt("t3", 4, 8'h10, 4);

      // Snapshot: two writes land during the transfer and form the next packet.
      push(3, 8'h20);
      wait_req("t4");
      grant();
      push(2, 8'h23);
      wait_idle("t4a");
      check_pkt("t4a", 3, 8'h20, 3);
      tick();
      chk("t4_rereq", port_req, 1);
      grant();
      wait_idle("t4b");
      check_pkt("t4b", 2, 8'h23, 2);

      // Ungranted request behaviour.
      push(5, 8'h30);
      wait_req("t5");
      hi = 0;
      while (port_req && hi < 40) begin
         hi++;
         tick();
      end
`ifdef QUEUE_RD_TIMEOUT_EN
      chk("t5_req_high", hi, 16);
      lo = 0;
      while (!port_req && lo < 10) begin
         lo++;
         tick();
      end
      chk("t5_req_low", lo, 1);
      chk("t5_req_again", port_req, 1);
`else
      lo = 0;
      chk("t5_req_high", hi, 40);
      chk("t5_req_low", lo, 0);
`endif
      grant();
      wait_idle("t5");
      check_pkt("t5", 5, 8'h30, 5);

      // Reset during beat 2 of 6.
      push(6, 8'h40);
      wait_req("t6");
      grant();
      tick();
      tick();
      chk("t6_beat2", out_data, 8'h41);
      chk("t6_beat2_vld", out_vld, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_vld", out_vld, 0);
      chk("t6_rst_eop", out_eop, 0);
      chk("t6_rst_req", port_req, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_rd_en", fifo_rd_en, 0);
      tick();
      tick();
      chk("t6_index_kept", fifo_index, 4);
      chk("t6_pops_before", pops, 2);
      rst = 1'b0;
      beat_q.delete();
      eop_q.delete();
      pops = 0;
      wait_req("t6b");
      chk("t6_rereq", port_req, 1);
      grant();
      wait_idle("t6b");
      check_pkt("t6b", 4, 8'h42, 4);

      chk("end_index", fifo_index, 0);
      chk("stable_while_held", stab_viol, 0);
      chk("pop_while_held", bp_pop_viol, 0);
      chk("pop_when_empty", empty_pop_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/queue_rd_ctrl.md
# queue_rd_ctrl

Read-side controller for one destination queue of the switch unit address decoder. It sits directly downstream of the queue FIFO and its occupancy counter, and drives the output port. When the queue is non-empty, it requests the output port from the port arbiter. After grant it snapshots the occupancy and drains exactly that many entries as one packet, using a registered valid/ready stream with end-of-packet marking.

## Interface
- DATA_WIDTH, 8: width of one queue entry and of out_data.
- FIFO_SIZE, 64: queue depth. Count width is CW = $clog2(FIFO_SIZE)+1.
- GNT_TIMEOUT, 16: consecutive ungranted REQ cycles before backoff. Only used with QUEUE_RD_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_index  in  CW  current queue occupancy from the occupancy counter.
- fifo_rd_data  in  DATA_WIDTH  head entry; first-word-fall-through, valid whenever fifo_index>0.
- fifo_rd_en  out  1  pop head entry this cycle; combinational.
- port_req  out  1  request/lock of the output port; registered.
- port_gnt  in  1  grant from the port arbiter.
- out_data  out  DATA_WIDTH  registered output beat.
- out_vld  out  1  out_data valid.
- out_eop  out  1  qualifies the final beat of the packet.
- out_rdy  in  1  downstream accepts the beat when out_vld && out_rdy.
- busy  out  1  state != IDLE.

## Operation
- Reset values:
  - state=IDLE; port_req=0; out_vld=0; out_eop=0; out_data=0.
  - remaining=0; to_cnt=0; fifo_rd_en=0; busy=0.
- State transitions:
  - IDLE: if fifo_index!=0, go to REQ.
  - REQ: port_req=1.
    - If port_gnt and fifo_index!=0: remaining<=fifo_index, go to XFER.
    - If port_gnt and fifo_index==0: go to IDLE.
    - With QUEUE_RD_TIMEOUT_EN, on the GNT_TIMEOUT-th consecutive ungranted cycle: go to BACKOFF.
  - XFER: port_req held at 1 (port locked).
    - Load condition: slot_free = !out_vld || out_rdy.
    - When slot_free && remaining>0: fifo_rd_en=1, out_data<=fifo_rd_data, out_vld<=1, out_eop<=(remaining==1), remaining<=remaining-1.
    - When slot_free && remaining==0: out_vld<=0 and out_eop<=0.
    - When the beat with out_eop is accepted (out_vld && out_eop && out_rdy): go to IDLE, port_req<=0.
  - BACKOFF: one cycle with port_req=0 and to_cnt cleared. Then go to REQ if fifo_index!=0, else IDLE.
- Packet boundary rule: entries written after the snapshot are not part of the current packet. They form the next packet after a return through IDLE.
- fifo_rd_en is asserted only in XFER with remaining>0. A pop therefore never occurs with fifo_index==0.
- port_gnt is ignored outside REQ.
- Deasserting port_gnt during XFER has no effect; the lock holds until end of packet.
- out_data and out_eop are held stable while out_vld && !out_rdy.

## Timing
- Occupancy to request: fifo_index goes non-zero in cycle t; port_req=1 from cycle t+1.
- Grant to data: port_gnt sampled at edge e; first out_vld=1 one cycle after e.
- Throughput: one beat per cycle while out_rdy=1. A packet of N entries occupies N consecutive out_vld cycles.
- Release: port_req falls on the edge after acceptance of the eop beat. The earliest next port_req is one cycle after that, via IDLE.
- Mid-operation reset: out_vld, out_eop and port_req drop immediately (asynchronously). No fifo_rd_en is issued while rst=1.
  - Entries already popped are lost; the FIFO keeps unread entries.

## Configuration
- QUEUE_RD_TIMEOUT_EN:
  - Defined: to_cnt (width $clog2(GNT_TIMEOUT)+1) counts consecutive REQ cycles without port_gnt; it is cleared on grant or on leaving REQ. Reaching GNT_TIMEOUT forces BACKOFF.
  - Not defined: to_cnt and BACKOFF are not compiled. REQ waits for port_gnt indefinitely.

## Test plan
- Single entry: write 1 entry (fifo_index=1), grant after 2 cycles, out_rdy=1 → exactly one out_vld beat with out_eop=1 and one fifo_rd_en pulse. port_req deasserts the edge after acceptance.
- Full queue: fifo_index=64, immediate grant, out_rdy=1 → 64 back-to-back beats in order, out_eop only on beat 64. busy falls 1 cycle after beat 64.
- Backpressure: 4 entries, out_rdy toggled 1,0,0,1,... → each beat is held stable while out_rdy=0. fifo_rd_en is never asserted while out_vld && !out_rdy. No data is lost or duplicated.
- Snapshot: fifo_index=3 at grant, 2 more writes during XFER → first packet is 3 beats with eop on beat 3. Controller returns to IDLE, re-requests, and sends a 2-beat packet.
- Timeout (with QUEUE_RD_TIMEOUT_EN): fifo_index=5, port_gnt held 0 → port_req high for 16 cycles, low for 1 cycle, then high again. Without the macro, port_req stays high continuously.
- Reset mid-packet: assert rst during beat 2 of 6 → out_vld, port_req and busy are 0 in the same cycle. After release, the controller re-requests for the remaining fifo_index.
